lvl_states_arbiter: RTL and testbench
=====================================

Name: lvl_states_arbiter

Overview:
- Shares the single level-states BRAM (one read port, one write port) between several requesters in bin_manager, e.g. the global backtrack-level finder, the decision-level recorder and the level-state clearer.
- Each requester raises a held "apply" request. The block grants exclusive BRAM ownership round-robin, muxes the owner's address/data onto the BRAM, and returns read-valid strobes aligned to the 1-cycle BRAM read latency.
- Sits between the requesters and the lvl-states BRAM, replacing ad-hoc apply-based muxing.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- WIDTH_LVL_STATES, 11, BRAM data width ({bin_id, has_bkt})
- ADDR_WIDTH_LVL_STATES, 9, BRAM address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- apply_i  in  NUM_REQ  per-requester ownership request, held for the whole access burst
- rd_en_i  in  NUM_REQ  per-requester read strobe
- raddr_i  in  NUM_REQ*ADDR_WIDTH_LVL_STATES  packed read addresses; requester k occupies slice k
- we_i  in  NUM_REQ  per-requester write enable
- waddr_i  in  NUM_REQ*ADDR_WIDTH_LVL_STATES  packed write addresses
- wdata_i  in  NUM_REQ*WIDTH_LVL_STATES  packed write data
- grant_o  out  NUM_REQ  one-hot registered grant
- rvalid_o  out  NUM_REQ  read data valid for requester k
- rdata_o  out  WIDTH_LVL_STATES  BRAM read data, broadcast to all requesters
- ram_raddr_o  out  ADDR_WIDTH_LVL_STATES  BRAM read address
- ram_rdata_i  in  WIDTH_LVL_STATES  BRAM read data, valid 1 cycle after the address
- ram_we_o  out  1  BRAM write enable
- ram_waddr_o  out  ADDR_WIDTH_LVL_STATES  BRAM write address
- ram_wdata_o  out  WIDTH_LVL_STATES  BRAM write data
- err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, grant_o=0, rvalid_o=0, err_o=0, rr pointer=0.
  - All ram_* outputs evaluate to 0 because no grant is held.
  - Reset mid-burst drops the grant immediately; no write is issued in that cycle.
- FSM states:
  - IDLE:
    - If any apply_i bit is set: pick the first set bit searching from rr_ptr upward with wrap. At the next edge set grant_o to that one-hot value and go to OWN.
    - Otherwise stay in IDLE.
    - Latency: apply rises at cycle t, grant_o is visible in cycle t+1.
  - OWN:
    - Stay while apply_i[owner]=1.
    - When apply_i[owner]=0: at the next edge clear grant_o, set rr_ptr=owner+1 (mod NUM_REQ) and go to GAP.
  - GAP:
    - One mandatory idle cycle with no grant, so in-flight reads drain.
    - Next state is IDLE; arbitration resumes from the next cycle.
    - Minimum hand-over: owner drops apply at cycle t, and the next grant is visible at cycle t+3 at the earliest.
- Datapath muxing is combinational from the registered grant:
  - ram_raddr_o = raddr slice of the owner, or 0 with no owner.
  - ram_we_o = we_i[owner] & (state==OWN).
  - ram_waddr_o and ram_wdata_o are the owner's slices when ram_we_o=1, else 0.
- Read valid:
  - Register (state==OWN & rd_en_i[owner]) together with the owner index.
  - Next cycle, assert rvalid_o[index]=1 and drive rdata_o = ram_rdata_i.
  - Result: rvalid_o is asserted exactly 1 cycle after rd_en. A read issued in the last OWN cycle still returns its rvalid during GAP.
- Simultaneous read and write by the owner to the same address: BRAM read-first semantics apply, so rdata_o returns the old value. The arbiter does no bypass.
- Requests that arrive while another requester owns the BRAM are held pending. A request that drops before being granted is simply forgotten.
- err_o (sticky until reset) is set when either:
  - we_i[k] or rd_en_i[k] is asserted while grant_o[k]=0; the access is ignored, never forwarded;
  - more than one grant_o bit is set (assertion backup).
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,0,... Each requester waits at most (NUM_REQ-1) bursts plus the GAP cycles.

Decomposition:
- Shared package lvl_states_pkg holds:
  - WIDTH_LVL_STATES and ADDR_WIDTH_LVL_STATES;
  - the FSM state encoding IDLE=0, OWN=1, GAP=2;
  - requester index constants REQ_FIND_BKT=0, REQ_RECORD=1, REQ_CLEAR=2.
- One sub-module, rr_pick_first: combinational round-robin priority picker taking (req vector, rr_ptr) and returning (one-hot, index, any). It is reused by other bin_manager arbiters.

Test Plan:
- Single owner: apply_i=3'b001 at cycle 0; rd_en at cycles 1-3, raddr 5,4,3 -> grant_o=001 at cycle 1; ram_raddr_o = 5,4,3; rvalid_o[0]=1 at cycles 2-4 with BRAM data.
- Write pass-through: requester 2 is granted, we=1, waddr=7, wdata=0x0FF -> ram_we_o=1, ram_waddr_o=7, ram_wdata_o=0x0FF in the same cycle; a readback from requester 0 later returns 0x0FF.
- Round-robin: apply_i=111 held; each owner holds for 2 cycles then drops and re-raises -> grant order 0,1,2,0, with one GAP cycle between each pair of owners.
- Violation: grant_o=001 while we_i[1]=1 -> ram_we_o stays 0, err_o=1 and remains 1 until rst=0.
- Reset mid-burst: owner 1 is writing when rst=0 for 1 cycle -> grant_o=0, ram_we_o=0, err_o=0, rr_ptr=0; with apply_i=110 afterwards, requester 1 is granted first.
- Last-cycle read: owner 0 drops apply in the same cycle as rd_en with raddr=9 -> rvalid_o[0]=1 during GAP; a new grant appears no earlier than 3 cycles after the drop.

Source files
------------

// File: rtl/lvl_states_pkg.sv
// Shared definitions for the level-states BRAM and its arbiter.
// Covers BRAM geometry, arbiter FSM encoding and requester index assignments.
// Imported by the arbiter top and its round-robin picker.
package lvl_states_pkg;

  // BRAM word is {bin_id, has_bkt}
  localparam int WIDTH_LVL_STATES      = 11;
  localparam int ADDR_WIDTH_LVL_STATES = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // Requester slots inside bin_manager
  localparam int REQ_FIND_BKT = 0;
  localparam int REQ_RECORD   = 1;
  localparam int REQ_CLEAR    = 2;

endpackage

// File: rtl/lvl_states_arbiter_rr_pick_first.sv
// rr_pick_first: combinational round-robin picker. It returns the first set bit
// of req, searching upward from ptr with wraparound.
// Ports: req (request vector), ptr (start index) -> onehot, idx, any (a bit was found).
// Latency: purely combinational. No state and no backpressure.
module rr_pick_first
  import lvl_states_pkg::*;
#(
  parameter int N    = 3,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  // Walk the offsets from the farthest down to the nearest. The nearest set
  // bit is written last, so it wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N]) begin
        idx = IDXW'((int'(ptr) + off) % N);
        any = 1'b1;
      end
    end
    onehot[idx] = any;
  end

endmodule

// File: rtl/lvl_states_arbiter.sv
// lvl_states_arbiter: round-robin ownership arbiter for the single level-states BRAM.
// Ports: clk/rst (sync, active-low); per-requester apply_i/rd_en_i/raddr_i/we_i/waddr_i/wdata_i;
//   grant_o (one-hot), rvalid_o, rdata_o (broadcast); ram_* connect to the BRAM; err_o is sticky.
// Latency: the grant appears 1 cycle after apply, and rvalid_o follows rd_en by 1 cycle.
//   Each hand-over inserts one GAP cycle. A request that is not granted waits.
module lvl_states_arbiter
  import lvl_states_pkg::*;
#(
  parameter int NUM_REQ               = 3,
  parameter int WIDTH_LVL_STATES      = lvl_states_pkg::WIDTH_LVL_STATES,
  parameter int ADDR_WIDTH_LVL_STATES = lvl_states_pkg::ADDR_WIDTH_LVL_STATES
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       apply_i,
  input  logic [NUM_REQ-1:0]                       rd_en_i,
  input  logic [NUM_REQ*ADDR_WIDTH_LVL_STATES-1:0] raddr_i,
  input  logic [NUM_REQ-1:0]                       we_i,
  input  logic [NUM_REQ*ADDR_WIDTH_LVL_STATES-1:0] waddr_i,
  input  logic [NUM_REQ*WIDTH_LVL_STATES-1:0]      wdata_i,
  output logic [NUM_REQ-1:0]                       grant_o,
  output logic [NUM_REQ-1:0]                       rvalid_o,
  output logic [WIDTH_LVL_STATES-1:0]              rdata_o,
  output logic [ADDR_WIDTH_LVL_STATES-1:0]         ram_raddr_o,
  input  logic [WIDTH_LVL_STATES-1:0]              ram_rdata_i,
  output logic                                     ram_we_o,
  output logic [ADDR_WIDTH_LVL_STATES-1:0]         ram_waddr_o,
  output logic [WIDTH_LVL_STATES-1:0]              ram_wdata_o,
  output logic                                     err_o
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW   = ADDR_WIDTH_LVL_STATES;
  localparam int DW   = WIDTH_LVL_STATES;

  arb_state_e          state, state_nxt;
  logic [NUM_REQ-1:0]  grant, grant_nxt;
  logic [IDXW-1:0]     owner, owner_nxt;
  logic [IDXW-1:0]     rr_ptr, rr_ptr_nxt;
  logic                rv_pend;
  logic [IDXW-1:0]     rv_idx;
  logic                err;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDXW-1:0]     pick_idx;
  logic                pick_any;

  logic                own_act;
  logic                viol;

  rr_pick_first #(
    .N    (NUM_REQ),
    .IDXW (IDXW)
  ) u_pick (
    .req    (apply_i),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Asserting rst releases the BRAM in the same cycle, so a burst interrupted
  // by reset issues no further write. The grant register clears at the edge.
  assign own_act = rst && (state == OWN);

  // Datapath mux driven by the registered owner
  always_comb begin
    ram_raddr_o = '0;
    ram_we_o    = 1'b0;
    ram_waddr_o = '0;
    ram_wdata_o = '0;
    if (own_act) begin
      ram_raddr_o = raddr_i[int'(owner)*AW +: AW];
      ram_we_o    = we_i[owner];
      if (we_i[owner]) begin
        ram_waddr_o = waddr_i[int'(owner)*AW +: AW];
        ram_wdata_o = wdata_i[int'(owner)*DW +: DW];
      end
    end
  end

  // A strobe from any non-owner is a protocol error. It is never forwarded
  // because the mux above only looks at the owner's lanes.
  assign viol = (|((we_i | rd_en_i) & ~grant)) || ($countones(grant) > 1);

  // Next-state logic for the ownership FSM
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_onehot;
          owner_nxt = pick_idx;
          state_nxt = OWN;
        end
      end
      OWN: begin
        if (!apply_i[owner]) begin
          grant_nxt  = '0;
          rr_ptr_nxt = (owner == IDXW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state_nxt  = GAP;
        end
      end
      GAP: begin
        // This cycle lets a read issued in the last OWN cycle return
        // before another requester can take the BRAM.
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      grant   <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      rv_pend <= 1'b0;
      rv_idx  <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      owner   <= owner_nxt;
      rr_ptr  <= rr_ptr_nxt;
      rv_pend <= own_act && rd_en_i[owner];
      rv_idx  <= owner;
      err     <= err | viol;
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (rv_pend) rvalid_o[rv_idx] = 1'b1;
  end

  assign grant_o = grant;
  assign rdata_o = ram_rdata_i;
  assign err_o   = err;

endmodule

// File: tb/tb_lvl_states_arbiter.sv
module tb_lvl_states_arbiter;

  localparam int N  = 3;
  localparam int AW = 9;
  localparam int DW = 11;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    apply_i = '0, rd_en_i = '0, we_i = '0;
  logic [N*AW-1:0] raddr_i = '0, waddr_i = '0;
  logic [N*DW-1:0] wdata_i = '0;
  logic [N-1:0]    grant_o, rvalid_o;
  logic [DW-1:0]   rdata_o, ram_rdata_i, ram_wdata_o;
  logic [AW-1:0]   ram_raddr_o, ram_waddr_o;
  logic            ram_we_o, err_o;

  lvl_states_arbiter #(
    .NUM_REQ               (N),
    .WIDTH_LVL_STATES      (DW),
    .ADDR_WIDTH_LVL_STATES (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .apply_i     (apply_i),
    .rd_en_i     (rd_en_i),
    .raddr_i     (raddr_i),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .grant_o     (grant_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .ram_raddr_o (ram_raddr_o),
    .ram_rdata_i (ram_rdata_i),
    .ram_we_o    (ram_we_o),
    .ram_waddr_o (ram_waddr_o),
    .ram_wdata_o (ram_wdata_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // Environment BRAM: read-first, 1-cycle read latency, driven only by the DUT
  logic [DW-1:0] bram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    ram_rdata_i <= bram[ram_raddr_o];
    if (ram_we_o) bram[ram_waddr_o] <= ram_wdata_o;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model. It tracks who owns the BRAM, whether a hand-over gap is
  // pending, where the round-robin search starts, and any expected read return.
  int            m_owner;
  bit            m_gap;
  int            m_rr;
  bit            m_err;
  bit            m_rv;
  int            m_rv_idx;
  logic [DW-1:0] m_rv_data;

  task automatic check_outputs();
    int            own;
    logic [N-1:0]  eg, erv;
    logic [AW-1:0] era, ewa;
    logic [DW-1:0] ewd;
    logic          ewe;
    own = (rst && m_owner >= 0) ? m_owner : -1;
    eg  = '0; erv = '0; era = '0; ewa = '0; ewd = '0; ewe = 1'b0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (own >= 0) begin
      era = raddr_i[own*AW +: AW];
      ewe = we_i[own];
      if (ewe) begin
        ewa = waddr_i[own*AW +: AW];
        ewd = wdata_i[own*DW +: DW];
      end
    end
    if (m_rv) erv[m_rv_idx] = 1'b1;
    chk("grant",     32'(grant_o),     32'(eg));
    chk("ram_raddr", 32'(ram_raddr_o), 32'(era));
    chk("ram_we",    32'(ram_we_o),    32'(ewe));
    chk("ram_waddr", 32'(ram_waddr_o), 32'(ewa));
    chk("ram_wdata", 32'(ram_wdata_o), 32'(ewd));
    chk("rvalid",    32'(rvalid_o),    32'(erv));
    chk("err",       32'(err_o),       32'(m_err));
    if (m_rv) chk("rdata", 32'(rdata_o), 32'(m_rv_data));
  endtask

  task automatic model_step();
    if (!rst) begin
      m_owner = -1; m_gap = 0; m_rr = 0; m_err = 0; m_rv = 0; m_rv_idx = 0;
    end else begin
      for (int k = 0; k < N; k++)
        if ((we_i[k] || rd_en_i[k]) && k != m_owner) m_err = 1;
      m_rv = 0;
      if (m_owner >= 0) begin
        m_rv      = rd_en_i[m_owner];
        m_rv_idx  = m_owner;
        m_rv_data = ref_mem[raddr_i[m_owner*AW +: AW]];
        if (we_i[m_owner]) ref_mem[waddr_i[m_owner*AW +: AW]] = wdata_i[m_owner*DW +: DW];
      end
      if (m_owner >= 0) begin
        if (!apply_i[m_owner]) begin
          m_rr    = (m_owner + 1) % N;
          m_owner = -1;
          m_gap   = 1;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else begin
        for (int off = 0; off < N; off++) begin
          if (m_owner < 0 && apply_i[(m_rr + off) % N]) m_owner = (m_rr + off) % N;
        end
      end
    end
  endtask

  // The caller drives inputs at edge+1. This task then checks, advances the
  // model, and waits for the next edge.
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit rd, input int ra, input bit w, input int wa, input int wd);
    rd_en_i[k]           = rd;
    raddr_i[k*AW +: AW]  = AW'(ra);
    we_i[k]              = w;
    waddr_i[k*AW +: AW]  = AW'(wa);
    wdata_i[k*DW +: DW]  = DW'(wd);
  endtask

  task automatic clr();
    rd_en_i = '0; we_i = '0; raddr_i = '0; waddr_i = '0; wdata_i = '0;
  endtask

  task automatic do_reset();
    clr(); rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  logic [N-1:0] order[$];
  logic [N-1:0] prev_g;
  int           held, n;
  int           burst[N];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      bram[i] = v;
      ref_mem[i] = v;
    end
    // Power-up reset. The model is put into its reset state without checking.
    @(posedge clk);
    #1;
    model_step();
    rst = 1'b1;

    // Reset state, then a single owner reading 5,4,3
    tick();
    apply_i = 3'b001; tick();
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1, 5 - i, 0, 0, 0); tick();
    end
    clr(); apply_i = '0; tick(); tick(); tick();

    // Requester 2 writes 0x0FF to address 7, then requester 0 reads it back
    apply_i = 3'b100; tick();
    set_req(2, 0, 0, 1, 7, 'h0FF); tick();
    clr(); apply_i = '0; tick(); tick();
    apply_i = 3'b001; tick();
    set_req(0, 1, 7, 0, 0, 0); tick();
    clr(); apply_i = '0; tick(); tick(); tick();

    // Round-robin with all requesters busy
    do_reset();
    prev_g = '0; held = 0;
    for (int c = 0; c < 20; c++) begin
      apply_i = 3'b111;
      if (m_owner >= 0) begin
        if (held >= 2) apply_i[m_owner] = 1'b0;
        held++;
      end else held = 0;
      if (grant_o != 0 && prev_g == 0) order.push_back(grant_o);
      prev_g = grant_o;
      tick();
    end
    chk("rr_count", 32'(order.size() >= 4), 32'd1);
    if (order.size() >= 4) begin
      chk("rr_0", 32'(order[0]), 32'b001);
      chk("rr_1", 32'(order[1]), 32'b010);
      chk("rr_2", 32'(order[2]), 32'b100);
      chk("rr_3", 32'(order[3]), 32'b001);
    end
    apply_i = '0; tick(); tick(); tick();

    // A write by a non-owner is flagged and stays flagged until reset
    apply_i = 3'b001; tick();
    set_req(1, 0, 0, 1, 3, 'h155); tick();
    clr(); tick(); tick();
    chk("err_sticky", 32'(err_o), 32'd1);
    apply_i = '0; tick(); tick();

    // Reset in the middle of a write burst by owner 1
    do_reset();
    apply_i = 3'b010; tick();
    set_req(1, 0, 0, 1, 20, 'h2AA); tick();
    rst = 1'b0; set_req(1, 0, 0, 1, 21, 'h3AA); tick();
    rst = 1'b1; clr(); apply_i = 3'b110; tick(); tick();
    chk("rst_first_grant", 32'(grant_o), 32'b010);
    apply_i = '0; tick(); tick(); tick();

    // A read in the owner's last cycle still returns, and hand-over takes 3 cycles
    apply_i = 3'b001; tick(); tick();
    apply_i = 3'b000; set_req(0, 1, 9, 0, 0, 0); tick();
    clr(); apply_i = 3'b010;
    n = 1;
    while (grant_o == 0 && n < 10) begin
      tick(); n++;
    end
    chk("handover", 32'(n), 32'd3);
    apply_i = '0; tick(); tick(); tick();

    // Randomized traffic with occasional violations and resets
    for (int k = 0; k < N; k++) burst[k] = 0;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      rd_en_i = '0; we_i = '0;
      for (int k = 0; k < N; k++) begin
        raddr_i[k*AW +: AW] = AW'($urandom_range(0, 15));
        waddr_i[k*AW +: AW] = AW'($urandom_range(0, 15));
        wdata_i[k*DW +: DW] = DW'($urandom);
        if (m_owner == k) begin
          apply_i[k] = (burst[k] > 0);
          burst[k]--;
          rd_en_i[k] = 1'($urandom_range(0, 1));
          we_i[k]    = ($urandom_range(0, 2) == 0);
        end else if (apply_i[k]) begin
          if ($urandom_range(0, 15) == 0) apply_i[k] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          apply_i[k] = 1'b1;
          burst[k]   = $urandom_range(0, 4);
        end
      end
      if ($urandom_range(0, 59) == 0) begin
        int v;
        v = $urandom_range(0, N - 1);
        if (v != m_owner) begin
          if ($urandom_range(0, 1) == 0) rd_en_i[v] = 1'b1;
          else we_i[v] = 1'b1;
        end
      end
      tick();
    end
    rst = 1'b1; clr(); apply_i = '0; tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
